pwr_cnt_seq: RTL

//   Parametrised successor to the 32-bit benchmark counter/decoder: a WIDTH-bit gated

---
 rtl/pwr_cnt_pkg.sv | 38 +++
 rtl/pwr_phase_seq.sv | 62 ++++++
 rtl/pwr_cnt_seq.sv | 92 +++++++++
 3 files changed

// File: rtl/pwr_cnt_pkg.sv
// Shared types and helpers for the pwr_cnt_seq counter/sequencer slice.
// Provides the sequencer state encoding and the per-bit clear-mask builder.
package pwr_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Upper bounds for clr_mask; instantiations must keep WIDTH <= MAX_W and CTRL_W <= MAX_CTRL.
    localparam int MAX_W    = 256;
    localparam int MAX_CTRL = 32;
    localparam int CIDX_W   = $clog2(MAX_CTRL);

    // Bit i of the returned mask is ctrl_q[i % ctrl_w]; bits at or above width are zero.
    function automatic logic [MAX_W-1:0] clr_mask(input logic [MAX_CTRL-1:0] ctrl_q,
                                                  input int                  ctrl_w,
                                                  input int                  width);
        logic [MAX_W-1:0]  m;
        logic [CIDX_W-1:0] j;
        m = '0;
        j = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                m[i] = ctrl_q[j];
            end
            // j walks 0..ctrl_w-1 repeatedly, i.e. i modulo ctrl_w
            if (j == CIDX_W'(ctrl_w - 1)) begin
                j = '0;
            end else begin
                j = j + 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pwr_phase_seq.sv
// Phase sequencer for pwr_cnt_seq: IDLE/RUN/DONE control FSM, phase counter
// advanced by all-ones events, and a one-cycle tick when the phase wraps into DONE.
module pwr_phase_seq
    import pwr_cnt_pkg::*;
#(
    parameter int PHASES = 8,
    parameter int PH_W   = $clog2(PHASES)
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            en,
    input  logic            full,
    output logic [PH_W-1:0] phase,
    output logic            tick,
    output logic            busy,
    output logic            run
);

    state_t state;

    // FSM, phase and tick; dropping en out of RUN wins over a same-cycle wrap
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state <= IDLE;
            phase <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (full) begin
                        // PHASES is a power of two, so the increment wraps naturally
                        phase <= phase + 1'b1;
                        if (phase == PH_W'(PHASES - 1)) begin
                            state <= DONE;
                            tick  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!en) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign run  = (state == RUN);

endmodule

// File: rtl/pwr_cnt_seq.sv
// Top of the gated counter / all-ones detector / phase sequencer load.
// Optional feature: define PWR_PARITY_EN to register the parity of the counter
// into parity_q; otherwise parity_q is tied low.
module pwr_cnt_seq
    import pwr_cnt_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int PHASES = 8,
    parameter int PH_W   = $clog2(PHASES)
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              en,
    input  logic              carry_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  cnt_q,
    output logic              full,
    output logic [PH_W-1:0]   phase,
    output logic              tick,
    output logic              busy,
    output logic              parity_q
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  cnt_d;
    logic              run;
    logic              inc;

    pwr_phase_seq #(
        .PHASES (PHASES),
        .PH_W   (PH_W)
    ) u_seq (
        .clk1  (clk1),
        .rst_n (rst_n),
        .en    (en),
        .full  (full),
        .phase (phase),
        .tick  (tick),
        .busy  (busy),
        .run   (run)
    );

    // Clear controls take effect one cycle after they are presented
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_in;
        end
    end

    assign mask = WIDTH'(clr_mask(MAX_CTRL'(ctrl_q), CTRL_W, WIDTH));
    assign inc  = carry_in & en;
    assign full = &cnt_q;

    // Next counter value: load beats counting, counting only while running
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (run) begin
            cnt_d = (cnt_q + WIDTH'(inc)) & ~mask;
        end
    end

    // Counter register
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef PWR_PARITY_EN
    // Parity tracks the value the counter is about to hold, so it lines up with cnt_q
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^cnt_d;
        end
    end
`else
    assign parity_q = 1'b0;
`endif

endmodule
